axi_burst_wr_slave: RTL and testbench
=====================================

AXI_BURST_WR_SLAVE -- requirements
Module: axi_burst_wr_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address mapped to memory word 0.
REQ-002 Parameter DEPTH, default 512: number of 64-bit memory words, power of two; AW = log2(DEPTH).
REQ-003 aclk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1, s_axi_awlen in 4, s_axi_awsize in 3, s_axi_awburst in 2: AXI3 write address channel.
REQ-006 s_axi_wdata in 64, s_axi_wstrb in 8, s_axi_wlast in 1, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
REQ-007 s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response channel.
REQ-008 rd_addr_i in AW, rd_data_o out 64: debug read port.
REQ-009 burst_cnt_o out 16: completed B handshakes; err_cnt_o out 16: SLVERR responses issued.

Function
REQ-010 The block SHALL be a single-outstanding AXI3 write responder with states S_IDLE, S_DATA and S_RESP; awready, wready and bvalid SHALL each be registered.
REQ-011 In S_IDLE, awready = 1; an AW handshake SHALL latch addr, len, size and burst, clear the beat counter, and set awready <= 0 and wready <= 1; the next state is S_DATA.
REQ-012 Burst error on AW: awsize != 3'b011, awburst != 2'b01 (INCR), or awaddr[2:0] != 0; SHALL set a sticky err flag.
REQ-013 Word index = (awaddr - BASE_ADDR) >> 3; a beat whose index is >= DEPTH SHALL be discarded and SHALL set err.
REQ-014 In S_DATA, each W handshake with err clear and index in range SHALL write wdata bytes where wstrb[i] = 1; disabled bytes stay unchanged.
REQ-015 Per beat: the index SHALL increment by 1, and the beat counter SHALL increment by 1.
REQ-016 Beats after a burst error SHALL still be accepted (wready stays 1) but not written.
REQ-017 On the handshake where beat == len:
- wlast = 0 SHALL set err; the beat SHALL still be written if otherwise legal.
- State SHALL go to S_RESP with wready <= 0 and bvalid <= 1.
REQ-018 A handshake with wlast = 1 and beat < len SHALL be written if legal, set err, and end the burst (go to S_RESP).
REQ-019 bresp SHALL be 2'b10 (SLVERR) if err is set, else 2'b00 (OKAY), and SHALL be stable while bvalid = 1.
REQ-020 In S_RESP, bvalid SHALL hold until bready = 1; at the handshake, bvalid <= 0, awready <= 1, the next state is S_IDLE, and burst_cnt_o increments.
- err_cnt_o increments on that handshake if bresp = SLVERR.
- Both counters wrap 0xFFFF -> 0.
REQ-021 Minimum spacing: AW accepted in cycle N, first beat accepted no earlier than N+1, bvalid no earlier than one cycle after the last beat, next awready one cycle after the B handshake.
REQ-022 wvalid outside S_DATA SHALL be ignored (wready = 0); awvalid outside S_IDLE SHALL be ignored.
REQ-023 rd_data_o SHALL be mem[rd_addr_i] registered, one-cycle latency; a read of a word written in the same cycle SHALL return the old data.

Reset
REQ-024 While rst_i = 1: state = S_IDLE, awready = 0, wready = 0, bvalid = 0, bresp = 2'b00, counters = 0, err = 0, beat counter = 0.
REQ-025 awready SHALL rise on the first clock edge after rst_i deasserts.
REQ-026 Memory contents SHALL be unspecified after reset and SHALL NOT be cleared.
REQ-027 Reset mid-burst SHALL abandon the burst without issuing a response.

Verification
REQ-028 No-stall 16-beat burst: AW at BASE_ADDR, len = 15, size = 3, INCR; data 0x1..0x10; wstrb = 0xFF; wlast on beat 15 -> mem[0..15] = 1..16, bresp = OKAY, burst_cnt_o = 1.
REQ-029 Stalls: wvalid low every 4th cycle and bready held low 5 cycles -> bvalid and bresp stable throughout; mem matches data; exactly 16 beats accepted.
REQ-030 Back-to-back bursts: second AW at BASE_ADDR + 128 -> mem[16..31] written, burst_cnt_o = 2, err_cnt_o = 0.
REQ-031 Protocol errors:
- Early wlast on beat 7 of len = 15 -> beats 0..7 written, SLVERR, err_cnt_o = 1, awready = 1 next cycle.
- awsize = 2 -> SLVERR and memory unchanged.
- AW at BASE_ADDR + 8*(DEPTH-4) with len = 15 -> last 4 words written, remaining beats dropped, SLVERR.
REQ-032 wstrb = 0x0F over a word preset to all-ones -> upper 32 bits remain 0xFFFF_FFFF.
REQ-033 rst_i asserted at beat 5 -> outputs and counters at reset values; a subsequent full burst completes OKAY.

Source files
------------

// File: rtl/axi_burst_wr_slave.sv
// Single-outstanding AXI3 INCR write responder backed by a 64-bit wide memory.
// Includes a registered debug read port and completion/error counters.
module axi_burst_wr_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 512,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          rst_i,
    input  logic [31:0]   s_axi_awaddr,
    input  logic          s_axi_awvalid,
    output logic          s_axi_awready,
    input  logic [3:0]    s_axi_awlen,
    input  logic [2:0]    s_axi_awsize,
    input  logic [1:0]    s_axi_awburst,
    input  logic [63:0]   s_axi_wdata,
    input  logic [7:0]    s_axi_wstrb,
    input  logic          s_axi_wlast,
    input  logic          s_axi_wvalid,
    output logic          s_axi_wready,
    output logic [1:0]    s_axi_bresp,
    output logic          s_axi_bvalid,
    input  logic          s_axi_bready,
    input  logic [AW-1:0] rd_addr_i,
    output logic [63:0]   rd_data_o,
    output logic [15:0]   burst_cnt_o,
    output logic [15:0]   err_cnt_o
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t      state_r, state_nxt;
    logic        awready_r, awready_nxt;
    logic        wready_r, wready_nxt;
    logic        bvalid_r, bvalid_nxt;
    logic [1:0]  bresp_r, bresp_nxt;
    logic        err_r, err_nxt;
    logic [3:0]  beat_r, beat_nxt;
    logic [3:0]  len_r, len_nxt;
    logic [31:0] idx_r, idx_nxt;
    logic [15:0] burst_cnt_r, burst_cnt_nxt;
    logic [15:0] err_cnt_r, err_cnt_nxt;

    logic [31:0] aw_off;
    logic        aw_hs, w_hs, b_hs;
    logic        aw_err, in_range, beat_err, wr_en;
    logic [63:0] mem [DEPTH];
    logic [63:0] rd_data_p1;

    assign aw_off   = s_axi_awaddr - BASE_ADDR;
    assign aw_hs    = (state_r == S_IDLE) && awready_r && s_axi_awvalid;
    assign w_hs     = wready_r && s_axi_wvalid;
    assign b_hs     = bvalid_r && s_axi_bready;
    assign aw_err   = (s_axi_awsize != 3'b011) || (s_axi_awburst != 2'b01) ||
                      (s_axi_awaddr[2:0] != 3'b000);
    assign in_range = idx_r < DEPTH_W;
    // An out-of-range beat, a missing wlast on the final beat, or an early wlast all poison the burst.
    assign beat_err = !in_range || ((beat_r == len_r) && !s_axi_wlast) ||
                      (s_axi_wlast && (beat_r != len_r));
    assign wr_en    = w_hs && !err_r && in_range;

    always_comb begin
        state_nxt     = state_r;
        awready_nxt   = awready_r;
        wready_nxt    = wready_r;
        bvalid_nxt    = bvalid_r;
        bresp_nxt     = bresp_r;
        err_nxt       = err_r;
        beat_nxt      = beat_r;
        len_nxt       = len_r;
        idx_nxt       = idx_r;
        burst_cnt_nxt = burst_cnt_r;
        err_cnt_nxt   = err_cnt_r;
        case (state_r)
            S_IDLE: begin
                awready_nxt = 1'b1;
                if (aw_hs) begin
                    awready_nxt = 1'b0;
                    wready_nxt  = 1'b1;
                    len_nxt     = s_axi_awlen;
                    idx_nxt     = {3'b000, aw_off[31:3]};
                    beat_nxt    = 4'd0;
                    err_nxt     = aw_err;
                    state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    beat_nxt = beat_r + 4'd1;
                    idx_nxt  = idx_r + 32'd1;
                    if (beat_err) err_nxt = 1'b1;
                    if (s_axi_wlast || (beat_r == len_r)) begin
                        wready_nxt = 1'b0;
                        bvalid_nxt = 1'b1;
                        bresp_nxt  = (err_r || beat_err) ? 2'b10 : 2'b00;
                        state_nxt  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    bvalid_nxt    = 1'b0;
                    awready_nxt   = 1'b1;
                    burst_cnt_nxt = burst_cnt_r + 16'd1;
                    if (bresp_r == 2'b10) err_cnt_nxt = err_cnt_r + 16'd1;
                    state_nxt     = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bresp_r     <= 2'b00;
            err_r       <= 1'b0;
            beat_r      <= 4'd0;
            len_r       <= 4'd0;
            idx_r       <= 32'd0;
            burst_cnt_r <= 16'd0;
            err_cnt_r   <= 16'd0;
        end else begin
            state_r     <= state_nxt;
            awready_r   <= awready_nxt;
            wready_r    <= wready_nxt;
            bvalid_r    <= bvalid_nxt;
            bresp_r     <= bresp_nxt;
            err_r       <= err_nxt;
            beat_r      <= beat_nxt;
            len_r       <= len_nxt;
            idx_r       <= idx_nxt;
            burst_cnt_r <= burst_cnt_nxt;
            err_cnt_r   <= err_cnt_nxt;
        end
    end

    // Memory stage: byte-masked write and read-before-write debug port (p1 = one cycle latency)
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (s_axi_wstrb[i]) mem[idx_r[AW-1:0]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
        rd_data_p1 <= mem[rd_addr_i];
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign rd_data_o     = rd_data_p1;
    assign burst_cnt_o   = burst_cnt_r;
    assign err_cnt_o     = err_cnt_r;

endmodule

// File: tb/tb_axi_burst_wr_slave.sv
// Directed bench for axi_burst_wr_slave: response scoreboard plus a shadow memory
// that is compared word by word through the debug read port.
module tb_axi_burst_wr_slave;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);
    localparam int          TMO   = 200;

    logic          aclk = 1'b0;
    logic          rst_i;
    logic [31:0]   s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [3:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic [63:0]   s_axi_wdata;
    logic [7:0]    s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] rd_addr_i;
    logic [63:0]   rd_data_o;
    logic [15:0]   burst_cnt_o;
    logic [15:0]   err_cnt_o;

    int          checks = 0;
    int          errors = 0;
    int          w_hs_cnt = 0;
    int          exp_burst = 0;
    int          exp_err = 0;
    logic [1:0]  exp_q [$];
    logic [63:0] shadow [DEPTH];
    bit          shadow_vld [DEPTH];

    axi_burst_wr_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .rst_i(rst_i),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .burst_cnt_o(burst_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (s_axi_wvalid && s_axi_wready) w_hs_cnt <= w_hs_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_high(input string tag, ref logic sig);
        int n = 0;
        while (sig !== 1'b1 && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (n >= TMO) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (shadow_vld[i]) begin
                rd_addr_i = AW'(i);
                @(negedge aclk);
                chk($sformatf("%s_mem%0d", tag, i), rd_data_o, shadow[i]);
            end
        end
    endtask

    // rst_beat >= 0 asserts reset while that beat is being offered.
    task automatic do_burst(input string tag, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int wl_beat,
                            input logic [63:0] dbase, input logic [7:0] strb, input bit stall,
                            input int bdelay, input int rst_beat, input bit probe);
        logic [31:0] word0, idx;
        logic [63:0] old0, d;
        logic [1:0]  exp;
        bit          err;
        int          lim, hs0;
        word0 = (addr - BASE) >> 3;
        err   = (size != 3'b011) || (burst != 2'b01) || (addr[2:0] != 3'b000);
        lim   = (wl_beat < len) ? wl_beat + 1 : len + 1;
        if (rst_beat >= 0) lim = rst_beat;
        old0  = probe ? shadow[word0] : 64'd0;
        for (int b = 0; b < lim; b++) begin
            idx = word0 + 32'(b);
            d   = dbase + 64'(b);
            if (idx >= 32'(DEPTH)) err = 1'b1;
            else if (!err) begin
                for (int k = 0; k < 8; k++) if (strb[k]) shadow[idx][8*k +: 8] = d[8*k +: 8];
                if (strb == 8'hFF) shadow_vld[idx] = 1'b1;
            end
            if (b == len && b != wl_beat) err = 1'b1;
            if (b == wl_beat && b < len) err = 1'b1;
        end
        if (rst_beat < 0) exp_q.push_back(err ? 2'b10 : 2'b00);
        hs0 = w_hs_cnt;
        if (probe) rd_addr_i = AW'(word0);

        s_axi_awaddr = addr; s_axi_awlen = 4'(len); s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        wait_high({tag, "_aw"}, s_axi_awready);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;

        for (int b = 0; b < lim; b++) begin
            if (stall && (b % 3 == 2)) begin
                s_axi_wvalid = 1'b0;
                @(negedge aclk);
            end
            s_axi_wdata = dbase + 64'(b); s_axi_wstrb = strb;
            s_axi_wlast = (b == wl_beat); s_axi_wvalid = 1'b1;
            wait_high({tag, "_w"}, s_axi_wready);
            @(negedge aclk);
            if (probe && b == 0) chk({tag, "_rd_old"}, rd_data_o, old0);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

        if (rst_beat >= 0) begin
            s_axi_wdata = dbase + 64'(rst_beat); s_axi_wvalid = 1'b1;
            rst_i = 1'b1;
            #1;
            chk({tag, "_rst_awready"}, 64'(s_axi_awready), 64'd0);
            chk({tag, "_rst_wready"}, 64'(s_axi_wready), 64'd0);
            chk({tag, "_rst_bvalid"}, 64'(s_axi_bvalid), 64'd0);
            chk({tag, "_rst_bresp"}, 64'(s_axi_bresp), 64'd0);
            chk({tag, "_rst_bcnt"}, 64'(burst_cnt_o), 64'd0);
            chk({tag, "_rst_ecnt"}, 64'(err_cnt_o), 64'd0);
            @(negedge aclk);
            rst_i = 1'b0; s_axi_wvalid = 1'b0;
            exp_burst = 0; exp_err = 0;
            @(negedge aclk);
            chk({tag, "_awready_rise"}, 64'(s_axi_awready), 64'd1);
            chk({tag, "_beats"}, 64'(w_hs_cnt - hs0), 64'(lim));
            return;
        end

        wait_high({tag, "_b"}, s_axi_bvalid);
        exp = exp_q.pop_front();
        for (int i = 0; i < bdelay; i++) begin
            chk({tag, "_bvalid_hold"}, 64'(s_axi_bvalid), 64'd1);
            chk({tag, "_bresp_hold"}, 64'(s_axi_bresp), 64'(exp));
            @(negedge aclk);
        end
        chk({tag, "_bresp"}, 64'(s_axi_bresp), 64'(exp));
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        exp_burst++;
        if (exp == 2'b10) exp_err++;
        chk({tag, "_awready_next"}, 64'(s_axi_awready), 64'd1);
        chk({tag, "_bvalid_low"}, 64'(s_axi_bvalid), 64'd0);
        chk({tag, "_burst_cnt"}, 64'(burst_cnt_o), 64'(exp_burst));
        chk({tag, "_err_cnt"}, 64'(err_cnt_o), 64'(exp_err));
        chk({tag, "_beats"}, 64'(w_hs_cnt - hs0), 64'(lim));
    endtask

    initial begin
        rst_i = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; rd_addr_i = '0;
        repeat (3) @(negedge aclk);
        chk("reset_awready", 64'(s_axi_awready), 64'd0);
        chk("reset_wready", 64'(s_axi_wready), 64'd0);
        chk("reset_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("reset_bresp", 64'(s_axi_bresp), 64'd0);
        chk("reset_burst_cnt", 64'(burst_cnt_o), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
        rst_i = 1'b0;
        @(negedge aclk);
        chk("awready_after_reset", 64'(s_axi_awready), 64'd1);

        do_burst("nostall", BASE, 15, 3'd3, 2'b01, 15, 64'h1, 8'hFF, 1'b0, 0, -1, 1'b0);
        check_mem("nostall");
        do_burst("b2b", BASE + 32'd128, 15, 3'd3, 2'b01, 15, 64'h200, 8'hFF, 1'b0, 0, -1, 1'b0);
        do_burst("stall", BASE + 32'd256, 15, 3'd3, 2'b01, 15, 64'h1000, 8'hFF, 1'b1, 5, -1, 1'b0);
        check_mem("b2b_stall");
        do_burst("early_wlast", BASE + 32'd384, 15, 3'd3, 2'b01, 7, 64'h300, 8'hFF, 1'b0, 0, -1, 1'b0);
        do_burst("size2", BASE, 15, 3'd2, 2'b01, 15, 64'hDEAD_0000, 8'hFF, 1'b0, 0, -1, 1'b0);
        do_burst("fixed", BASE + 32'd128, 3, 3'd3, 2'b00, 3, 64'hBEEF_0000, 8'hFF, 1'b0, 0, -1, 1'b0);
        do_burst("oor", BASE + 32'(8 * (DEPTH - 4)), 15, 3'd3, 2'b01, 15, 64'h600, 8'hFF, 1'b0, 2, -1, 1'b0);
        do_burst("preset", BASE + 32'(8 * 56), 0, 3'd3, 2'b01, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 0, -1, 1'b0);
        do_burst("strb", BASE + 32'(8 * 56), 0, 3'd3, 2'b01, 0, 64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b0, 0, -1, 1'b0);
        rd_addr_i = AW'(56);
        @(negedge aclk);
        chk("strb_word", rd_data_o, 64'hFFFF_FFFF_9ABC_DEF0);
        check_mem("errors");

        do_burst("rst_mid", BASE, 15, 3'd3, 2'b01, 15, 64'h700, 8'hFF, 1'b0, 0, 5, 1'b0);
        do_burst("post_rst", BASE, 15, 3'd3, 2'b01, 15, 64'h800, 8'hFF, 1'b0, 1, -1, 1'b1);
        check_mem("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
